// File: rtl/prime_candidate_sieve_pkg.sv
// ============================================================================
// Module : prime_sieve_pkg
// Brief  : Shared types and constants for the prime candidate sieve.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package prime_sieve_pkg;

    localparam int REM_W      = 5;
    localparam int MAX_PRIMES = 8;

    // Entry [0] is the first prime tried.
    localparam logic [MAX_PRIMES-1:0][REM_W-1:0] SIEVE_PRIMES = {
        5'd23, 5'd19, 5'd17, 5'd13, 5'd11, 5'd7, 5'd5, 5'd3
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DIV   = 3'd2,
        CHECK = 3'd3,
        OUT   = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/prime_candidate_sieve_if.sv
// ============================================================================
// Module : prime_candidate_sieve_if
// Brief  : Control and candidate-stream bundle of the prime candidate sieve.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prime_candidate_sieve_if #(
    parameter int WIDTH = 64
) ();

    logic             start;
    logic             stop;
    logic [WIDTH-1:0] seed;
    logic             busy;
    logic [WIDTH-1:0] cand;
    logic             cand_valid;
    logic             cand_ready;
    logic             exhausted;

    modport master (
        input  start, stop, seed, cand_ready,
        output busy, cand, cand_valid, exhausted
    );

    modport slave (
        output start, stop, seed, cand_ready,
        input  busy, cand, cand_valid, exhausted
    );

endinterface

`default_nettype wire

// File: rtl/prime_candidate_sieve_serial_mod_small.sv
// ============================================================================
// Module : serial_mod_small
// Brief  : Bit-serial remainder of an MSB-first operand modulo a 5-bit prime.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_mod_small
    import prime_sieve_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             en_i,
    input  wire logic             bit_i,
    input  wire logic [REM_W-1:0] prime_i,
    output logic      [REM_W-1:0] rem_o
);

    logic [REM_W-1:0] rem_q, rem_d;
    logic [REM_W:0]   w_shift;
    logic [REM_W:0]   w_prime_ext;

    // rem < prime keeps 2*rem+1 below 2*prime, so one subtraction suffices.
    always_comb begin
        w_shift     = {rem_q, bit_i};
        w_prime_ext = {1'b0, prime_i};
        rem_d       = rem_q;
        if (clr_i) begin
            rem_d = '0;
        end else if (en_i) begin
            if (w_shift >= w_prime_ext) begin
                rem_d = REM_W'(w_shift - w_prime_ext);
            end else begin
                rem_d = w_shift[REM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem_o = rem_q;

endmodule

`default_nettype wire

// File: rtl/prime_candidate_sieve.sv
// ============================================================================
// Module : prime_candidate_sieve
// Brief  : Walks odd integers from a seed, trial-divides by small primes and
//          streams survivors. Optional macro SIEVE_STATS_EN adds reject_cnt.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prime_candidate_sieve
    import prime_sieve_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int NUM_PRIMES = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    prime_candidate_sieve_if.master  bus
`ifdef SIEVE_STATS_EN
    ,
    output logic [31:0]              reject_cnt
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int IDX_W = 3;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               exh_q, exh_d;

    logic [REM_W-1:0]   w_prime;
    logic [REM_W-1:0]   w_rem;
    logic               w_mod_clr;
    logic               w_mod_en;
    logic [CNT_W-1:0]   w_bit_idx;
    logic [WIDTH-1:0]   w_cur_inc;
    logic               w_cur_ovf;
    logic               w_rem_hit;

    assign w_prime   = SIEVE_PRIMES[idx_q];
    assign w_bit_idx = CNT_W'(WIDTH - 1) - cnt_q;
    assign {w_cur_ovf, w_cur_inc} = {1'b0, cur_q} + (WIDTH + 1)'(2);
    // A prime equal to the candidate itself must not reject it.
    assign w_rem_hit = (w_rem == '0) && (cur_q != WIDTH'(w_prime));

    serial_mod_small u_mod (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_mod_clr),
        .en_i    (w_mod_en),
        .bit_i   (cur_q[w_bit_idx]),
        .prime_i (w_prime),
        .rem_o   (w_rem)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        exh_d     = 1'b0;
        w_mod_clr = 1'b0;
        w_mod_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cur_d   = (bus.seed >= WIDTH'(3)) ? (bus.seed | WIDTH'(1)) : WIDTH'(3);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d     = '0;
                cnt_d     = '0;
                w_mod_clr = 1'b1;
                state_d   = DIV;
            end
            DIV: begin
                w_mod_en = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                w_mod_clr = 1'b1;
                cnt_d     = '0;
                if (w_rem_hit) begin
                    if (w_cur_ovf) begin
                        exh_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cur_d   = w_cur_inc;
                        state_d = LOAD;
                    end
                end else if (idx_q == IDX_W'(NUM_PRIMES - 1)) begin
                    state_d = OUT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = DIV;
                end
            end
            OUT: begin
                if (bus.cand_ready) begin
                    if (w_cur_ovf) begin
                        exh_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cur_d   = w_cur_inc;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort outranks any handshake or exhaustion in the same cycle.
        if (state_q != IDLE && bus.stop) begin
            state_d = IDLE;
            cur_d   = cur_q;
            exh_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exh_q   <= exh_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.cand_valid = (state_q == OUT);
    assign bus.cand       = cur_q;
    assign bus.exhausted  = exh_q;

`ifdef SIEVE_STATS_EN
    logic [31:0] rej_q;
    logic        w_reject;

    assign w_reject = (state_q == CHECK) && w_rem_hit && !bus.stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            rej_q <= '0;
        end else if (w_reject && rej_q != '1) begin
            rej_q <= rej_q + 32'd1;
        end
    end

    assign reject_cnt = rej_q;
`endif

endmodule

`default_nettype wire

// File: doc/prime_candidate_sieve.md
Name: prime_candidate_sieve

Overview:
Upstream feeder for the Miller-Rabin primality stage. It takes a seed and walks the odd integers at or above it. Each candidate is trial-divided by a fixed table of small odd primes using a bit-serial remainder unit. Only survivors are presented on a valid/ready output for the Miller-Rabin stage to consume, which keeps the costly modular-exponentiation stage from running on trivially composite inputs.

Parameters:
- WIDTH, 64, candidate bit width; matches the Miller-Rabin n input.
- NUM_PRIMES, 8, number of sieve primes used, taken in order from the package table {3,5,7,11,13,17,19,23}; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- stop  in  1  abort request; honoured in any non-IDLE state
- seed  in  WIDTH  starting value; sampled with start
- busy  out  1  high in every state except IDLE
- cand  out  WIDTH  surviving candidate
- cand_valid  out  1  cand is valid
- cand_ready  in  1  downstream accept
- exhausted  out  1  one-cycle pulse when the candidate space overflows

Behaviour:
- Reset: state IDLE; busy, cand_valid and exhausted are 0; cand is 0; internal cur, rem and prime index are 0. Reset mid-operation aborts immediately, and no partial handshake survives.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD (1 cycle) -> DIV.
  - DIV (WIDTH cycles) -> CHECK.
  - CHECK (1 cycle) -> DIV (next prime), OUT, or LOAD (next candidate).
  - OUT: waits for handshake.
- LOAD: cur <= (seed | 1) when seed >= 3, else cur <= 3. Prime index <= 0 and rem <= 0.
- DIV: the sub-module shifts in cur MSB-first, one bit per cycle: r' = 2r + bit, minus p when the result is >= p. rem is 5 bits wide, with a 6-bit intermediate.
- CHECK outcomes:
  - Fail when rem == 0 and cur != p. Then cur <= cur + 2 and the state goes to LOAD (which keeps cur, resets the index and rem).
  - Pass when rem != 0 or cur == p. Small primes are therefore emitted as themselves.
  - Pass on the last index -> OUT. Pass on any other index -> index + 1, DIV.
- Latency: for a first-try survivor, cand_valid rises exactly 1 + NUM_PRIMES*(WIDTH+1) cycles after start is sampled (521 with defaults). Each rejected candidate adds 1 + (k+1)*(WIDTH+1) cycles, where k is the index of the failing prime.
- OUT:
  - cand = cur and cand_valid = 1.
  - cand is held stable while cand_ready is low; valid never drops without a handshake, except on stop or rst.
  - On handshake (valid & ready), cand_valid = 0 the next cycle, cur <= cur + 2, and the state goes to LOAD. Streaming continues until stop.
- Wrap-around: if cur + 2 overflows WIDTH bits, exhausted pulses for one cycle, the state goes to IDLE, and no wrapped value is ever tested.
- stop: the next state is IDLE, cand_valid is 0 and busy is 0 the following cycle. stop has priority over a same-cycle handshake, which is treated as not accepted.
- start is ignored while busy. start and stop asserted together in IDLE: start wins.

Optional Feature:
- SIEVE_STATS_EN:
  - Defined: adds output reject_cnt[31:0]. It counts candidates rejected since the last start, clears on rst or on a start in IDLE, and saturates at 2^32-1.
  - Undefined: the port and counter are absent; core behaviour is identical.

Decomposition:
- Package prime_sieve_pkg:
  - state enum {IDLE, LOAD, DIV, CHECK, OUT}
  - SIEVE_PRIMES constant array of 8 five-bit primes
  - REM_W = 5
- One natural sub-module, serial_mod_small: a bit-serial remainder of a WIDTH-bit value modulo a 5-bit prime. It has clear/enable/bit-in inputs and a rem output, and produces its result after WIDTH enables.

Test Plan:
- seed 24, ready tied high -> 25 and 27 rejected, cand 29; cand_valid first rises at 1+1*65 + 1+2*65 + 1+8*65 = 718 cycles after start.
- seed 0 -> cand 3 at cycle 521. Continue streaming -> 5, 7, 11, 13, 17, 19, 23, 29.
- seed 529 -> 529 (23²), 531, 533, 535, 537 and 539 rejected; cand 541. With SIEVE_STATS_EN, reject_cnt = 6.
- seed 89, cand_ready low for 10 cycles after valid -> cand holds 89 and valid stays high; after ready, the next cand is 97.
- seed 2^64-1 (divisible by 3) -> rejected; +2 overflows -> exhausted single pulse, IDLE, cand_valid never asserted.
- seed 1000, stop 20 cycles after start -> busy = 0 and cand_valid = 0 the next cycle. A repeat with rst in OUT gives all outputs at reset values.
